// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int stage_w(input int w);
        return w;
    endfunction

    // Product of N_IN W-bit operands never exceeds N_IN*W bits.
    function automatic int res_w(input int n_in, input int w);
        return n_in * w;
    endfunction

endpackage

// File: rtl/dsc_stage_ctr.sv
// One clock-division stage: holds its operand and a W-bit counter; the stage bit is
// high while the counter is still below the operand.
module dsc_stage_ctr
    import dsc_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] op_in,
    input  logic         inc,
    output logic         stage_bit,
    output logic         at_max,
    output logic         at_op_m1
);

    localparam int SW = stage_w(W);

    logic [SW-1:0] op;
    logic [SW-1:0] ctr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op  <= '0;
            ctr <= '0;
        end else if (load) begin
            op  <= op_in;
            ctr <= '0;
        end else if (inc) begin
            ctr <= ctr + SW'(1);
        end
    end

    assign stage_bit = (op > ctr);
    assign at_max    = &ctr;
    // Only meaningful when op != 0, which the top guarantees before entering RUN.
    assign at_op_m1  = (ctr == op - SW'(1));

endmodule

// File: rtl/dsc_mul_n.sv
// N_IN-operand deterministic stochastic multiplier: clock-division stage chain,
// AND of stage bits forms the product stream, accumulator counts its ones.
module dsc_mul_n
    import dsc_pkg::*;
#(
    parameter int N_IN      = 3,
    parameter int W         = 10,
    parameter bit FAST_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_IN*W-1:0]   a_flat,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [N_IN*W-1:0]   z,
    output logic                sn_out
);

    localparam int ZW = res_w(N_IN, W);
    // Outermost stage terminates on its operand in fast-exit mode, others on all-ones.
    localparam logic [N_IN-1:0] TSEL = {FAST_EXIT, {(N_IN-1){1'b0}}};

    state_t state, next;

    logic [N_IN-1:0] stage_bit, at_max, at_op_m1, lower_max, inc, op_zero, term;
    logic            load, run, last, prod_bit;

    assign load = (state == IDLE) && start;
    assign run  = (state == RUN);

    genvar i;
    generate
        for (i = 0; i < N_IN; i++) begin : g_stage
            if (i == 0) begin : g_first
                assign lower_max[i] = 1'b1;
            end else begin : g_rest
                assign lower_max[i] = lower_max[i-1] & at_max[i-1];
            end

            assign inc[i]     = run & lower_max[i];
            assign op_zero[i] = (a_flat[i*W +: W] == '0);

            dsc_stage_ctr #(.W(W)) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load),
                .op_in     (a_flat[i*W +: W]),
                .inc       (inc[i]),
                .stage_bit (stage_bit[i]),
                .at_max    (at_max[i]),
                .at_op_m1  (at_op_m1[i])
            );
        end
    endgenerate

    assign term     = (TSEL & at_op_m1) | (~TSEL & at_max);
    assign last     = &term;
    assign prod_bit = &stage_bit;

    always_comb begin
        next = state;
        case (state)
            IDLE: if (start) next = (|op_zero) ? DONE : RUN;
            RUN:  if (last)  next = DONE;
            DONE:            next = IDLE;
            default:         next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            z     <= '0;
            done  <= 1'b0;
        end else begin
            state <= next;
            done  <= (next == DONE);
            if (load)
                z <= '0;
            else if (run)
                z <= z + ZW'(prod_bit);
        end
    end

    assign ready  = (state == IDLE);
    assign busy   = run;
    // Product bit of the current RUN cycle, aligned with its accumulation.
    assign sn_out = run & prod_bit;

endmodule
